// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared RV32M func3 codes, FSM encoding and op-class helper.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_ADJUST = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic logic is_div(input logic [2:0] f);
        return f >= MD_DIV;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            div_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    // Multiply: {hi,lo} holds partial product over multiplier; divide: remainder over dividend/quotient.
    assign sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    assign diff = {hi_i, lo_i[XLEN-1]} - {1'b0, b_i};

    assign hi_o = div_i ? (diff[XLEN] ? {hi_i[XLEN-2:0], lo_i[XLEN-1]} : diff[XLEN-1:0]) : sum[XLEN:1];
    assign lo_o = div_i ? {lo_i[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo_i[XLEN-1:1]};

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with fixed latency, FSM-sequenced.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d, res_q, res_d;
    logic [2:0]        f3_q, f3_d;
    logic              na_q, na_d, nb_q, nb_d;
    logic              a_neg, b_neg, accept;
    logic [XLEN-1:0]   step_hi, step_lo, quot, rem, adj;
    logic [2*XLEN-1:0] prod;

    assign a_neg  = op_a[XLEN-1] & (func3 == MD_MUL || func3 == MD_MULH || func3 == MD_MULHSU ||
                                    func3 == MD_DIV || func3 == MD_REM);
    assign b_neg  = op_b[XLEN-1] & (func3 == MD_MUL || func3 == MD_MULH || func3 == MD_DIV || func3 == MD_REM);
    assign accept = start & (state_q == S_IDLE || state_q == S_DONE);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .div_i (is_div(f3_q)),
        .hi_i  (acc_q[2*XLEN-1:XLEN]),
        .lo_i  (acc_q[XLEN-1:0]),
        .b_i   (b_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    // Divide-by-zero leaves an all-ones quotient that must not be sign-corrected.
    assign prod = (na_q ^ nb_q) ? -acc_q : acc_q;
    assign quot = ((na_q ^ nb_q) && b_q != '0) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem  = na_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign adj  = is_div(f3_q) ? (f3_q[1] ? rem : quot)
                               : (f3_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        f3_d    = f3_q;
        na_d    = na_q;
        nb_d    = nb_q;
        res_d   = res_q;
        if (flush) begin
            state_d = S_IDLE;
        end else if (accept) begin
            state_d = S_CALC;
            cnt_d   = CNT_W'(XLEN - 1);
            f3_d    = func3;
            na_d    = a_neg;
            nb_d    = b_neg;
            b_d     = b_neg ? -op_b : op_b;
            acc_d   = {{XLEN{1'b0}}, a_neg ? -op_a : op_a};
        end else if (state_q == S_CALC) begin
            acc_d   = {step_hi, step_lo};
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            state_d = cnt_q == '0 ? S_ADJUST : S_CALC;
        end else if (state_q == S_ADJUST) begin
            res_d   = adj;
            state_d = S_DONE;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            na_q    <= 1'b0;
            nb_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            res_q   <= res_d;
        end
    end

    assign busy   = state_q == S_CALC || state_q == S_ADJUST;
    assign done   = state_q == S_DONE;
    assign result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized + directed check of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  func3;
    logic [31:0] op_a, op_b, result;
    logic        busy, done;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin p = sa / sb; r = b == 0 ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : p[31:0]; end
            3'd5: begin p = ua / ub; r = b == 0 ? 32'hFFFFFFFF : p[31:0]; end
            3'd6: begin p = sa % sb; r = b == 0 ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : p[31:0]; end
            default: begin p = ua % ub; r = b == 0 ? a : p[31:0]; end
        endcase
        return r;
    endfunction

    // Called on a falling edge with the unit in IDLE or DONE; returns on the falling edge where done is seen.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit noise);
        int n, nb;
        bit changed;
        logic [31:0] exp, prev;
        exp = (b == 0 && f < 4) ? 32'h0 : ref_md(f, a, b);
        exp = ref_md(f, a, b);
        prev = result;
        changed = 0;
        start = 1'b1; func3 = f; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        nb = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            if (result !== prev) changed = 1;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                func3 = 3'($urandom);
                op_a = $urandom;
                op_b = $urandom;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("latency", n, 34);
        check("busy_cycles", nb, 33);
        check("done_busy_excl", {31'b0, busy}, 0);
        check("result_hold", {31'b0, changed}, 0);
        check($sformatf("res f%0d %h,%h", f, a, b), result, exp);
    endtask

    task automatic op_single(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit noise);
        run_op(f, a, b, noise);
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 0);
    endtask

    initial begin
        logic [31:0] prev, a, b;
        logic [2:0] f;
        int seen;
        reset = 1'b1; start = 1'b0; flush = 1'b0; func3 = '0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_result", result, 0);
        reset = 1'b0;
        @(negedge clk);

        op_single(3'd0, 32'h00000007, 32'hFFFFFFFD, 0);
        op_single(3'd1, 32'h80000000, 32'h80000000, 0);
        op_single(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        op_single(3'd2, 32'hFFFFFFFF, 32'h00000002, 0);
        op_single(3'd4, 32'hFFFFFFF9, 32'h00000002, 0);
        op_single(3'd6, 32'hFFFFFFF9, 32'h00000002, 0);
        op_single(3'd5, 32'd100, 32'd7, 0);
        op_single(3'd7, 32'd100, 32'd7, 0);
        op_single(3'd5, 32'd5, 32'd0, 0);
        op_single(3'd6, 32'd5, 32'd0, 0);
        op_single(3'd4, 32'hFFFFFFFB, 32'd0, 0);
        op_single(3'd6, 32'hFFFFFFFB, 32'd0, 0);
        op_single(3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
        op_single(3'd6, 32'h80000000, 32'hFFFFFFFF, 1);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if (i % 4 == 0) run_op(f, a, b, i % 2 == 1);
            else op_single(f, a, b, i % 2 == 1);
        end

        // Flush partway through a divide: no done pulse, result untouched.
        op_single(3'd0, 32'd3, 32'd5, 0);
        prev = result;
        start = 1'b1; func3 = 3'd4; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'b0, busy}, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("flush_no_done", seen, 0);
        check("flush_result", result, prev);

        start = 1'b1; flush = 1'b1; func3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start", {31'b0, busy}, 0);
        op_single(3'd0, 32'd3, 32'd5, 0);

        start = 1'b1; func3 = 3'd7; op_a = 32'd77; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midop_rst_busy", {31'b0, busy}, 0);
        check("midop_rst_result", result, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        op_single(3'd7, 32'd77, 32'd5, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
